// File: rtl/dff_arb_pkg.sv
// Shared opcodes, FSM encoding and bank geometry for the two-requester
// register-bank arbiter.
package dff_arb_pkg;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [1:0] OP_RD     = 2'b00;
  localparam logic [1:0] OP_WR     = 2'b01;
  localparam logic [1:0] OP_CLR    = 2'b10;
  localparam logic [1:0] OP_CLRALL = 2'b11;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_CLR   = 2'd2
  } state_t;

endpackage

// File: rtl/dff_bank_regs.sv
// DEPTH x WIDTH register bank: falling-edge write/clear on one port,
// combinational read on another, async active-low clear of every entry.
module dff_bank_regs
  import dff_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             clr,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Clear takes precedence so a single enable decode is never ambiguous.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      mem[addr] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter between requesters a and b sharing one register bank.
// Define DFF_ARB_LOCK_EN to add lock_a/lock_b, letting a winner keep the bank.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [1:0]       op_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] wdata_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [1:0]       op_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] wdata_b,
  output logic             gnt_b,
`ifdef DFF_ARB_LOCK_EN
  input  logic             lock_a,
  input  logic             lock_b,
`endif
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             rsel,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             win_q;
  logic             prio_q;
  logic [1:0]       op_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [AW-1:0]    clr_idx_q;
`ifdef DFF_ARB_LOCK_EN
  logic             lock_pend_q;
`endif

  logic             pick_b;
  logic [1:0]       pick_op;
  logic [AW-1:0]    pick_addr;
  logic [WIDTH-1:0] pick_wdata;
  logic             grant;
  logic             bank_we;
  logic             bank_clr;
  logic [AW-1:0]    bank_addr;
  logic [WIDTH-1:0] bank_rdata;

  dff_bank_regs #(.WIDTH(WIDTH)) u_regs (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we),
    .clr   (bank_clr),
    .addr  (bank_addr),
    .wdata (wdata_q),
    .raddr (addr_q),
    .rdata (bank_rdata)
  );

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // prio_q names the requester that wins a tie; a lone requester always wins.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    bank_we   = 1'b0;
    bank_clr  = 1'b0;
    bank_addr = addr_q;
    pick_b    = req_b && (!req_a || prio_q);
`ifdef DFF_ARB_LOCK_EN
    if (lock_pend_q && (win_q ? req_b : req_a)) pick_b = win_q;
`endif
    pick_op    = pick_b ? op_b    : op_a;
    pick_addr  = pick_b ? addr_b  : addr_a;
    pick_wdata = pick_b ? wdata_b : wdata_a;

    case (state_q)
      ST_IDLE: begin
        if (req_a || req_b) state_d = (pick_op == OP_CLRALL) ? ST_CLR : ST_SERVE;
      end
      ST_SERVE: begin
        grant    = 1'b1;
        bank_we  = (op_q == OP_WR);
        bank_clr = (op_q == OP_CLR);
        state_d  = ST_IDLE;
      end
      ST_CLR: begin
        bank_clr  = 1'b1;
        bank_addr = clr_idx_q;
        if (clr_idx_q == LAST_IDX) begin
          grant   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    gnt_a = grant && !win_q;
    gnt_b = grant &&  win_q;
  end

  assign busy = (state_q != ST_IDLE);

  // A lock only biases the IDLE cycle right after its grant, then expires.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      win_q     <= 1'b0;
      prio_q    <= 1'b0;
      op_q      <= OP_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      clr_idx_q <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      rsel      <= 1'b0;
`ifdef DFF_ARB_LOCK_EN
      lock_pend_q <= 1'b0;
`endif
    end else begin
      rvalid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_a || req_b) begin
            win_q     <= pick_b;
            op_q      <= pick_op;
            addr_q    <= pick_addr;
            wdata_q   <= pick_wdata;
            clr_idx_q <= '0;
          end
        end
        ST_SERVE: begin
          if (op_q == OP_RD) begin
            rdata  <= bank_rdata;
            rvalid <= 1'b1;
            rsel   <= win_q;
          end
        end
        ST_CLR:  clr_idx_q <= clr_idx_q + 1'b1;
        default: ;
      endcase
      if (grant) prio_q <= ~win_q;
`ifdef DFF_ARB_LOCK_EN
      if (state_q == ST_IDLE) lock_pend_q <= 1'b0;
      if (grant) lock_pend_q <= win_q ? lock_b : lock_a;
`endif
    end
  end

endmodule

// File: doc/dff_bank_arbiter.md
DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, data bits per register entry.
REQ-002 SHALL have ports:
- clk  in  1  single clock; all state updates on its falling edge.
- rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have, per requester x in {a,b}:
- req_x  in  1  request; held high with op/addr/wdata stable until gnt_x.
- op_x  in  2  00 read, 01 write, 10 clear entry, 11 clear all.
- addr_x  in  2  entry index 0..3.
- wdata_x  in  WIDTH  write data.
- gnt_x  out  1  one-cycle completion pulse.
REQ-004 SHALL have shared outputs:
- rdata  out  WIDTH  read data.
- rvalid  out  1  one-cycle pulse, rdata valid.
- rsel  out  1  0=rdata for a, 1=for b.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-005 SHALL own a 4-entry x WIDTH register bank shared between requesters a and b.
REQ-006 SHALL implement FSM states IDLE, SERVE, CLR.
REQ-007 IDLE: no req -> stay. Any req -> pick winner, latch its op/addr/wdata. Then go to CLR with clr_idx=0 if op=11, else SERVE.
REQ-008 Round-robin: a has priority out of reset. After any grant, the loser gets priority. A lone requester always wins.
REQ-009 SERVE (one cycle), executing latched op:
- write: bank[addr]<=wdata.
- clear entry: bank[addr]<=0.
- read: rdata<=bank[addr], rvalid=1 and rsel=winner on the following cycle.
- gnt_winner=1; next state IDLE.
REQ-010 CLR: each cycle clears bank[clr_idx] and increments clr_idx. It spends exactly 4 cycles (idx 0..3). gnt_winner=1 in the idx=3 cycle, then IDLE.
REQ-011 SHALL give a minimum request-to-gnt latency of 2 cycles (IDLE latch + SERVE), or 5 for clear-all. Back-to-back ops take 2 cycles each.
REQ-012 Deasserting req after latch SHALL NOT cancel the operation. Requests arriving while busy wait in IDLE.
REQ-013 SHALL never assert gnt_a and gnt_b in the same cycle. gnt SHALL never be asserted in IDLE.
REQ-014 A read of an entry written or cleared earlier SHALL return the updated value; there is no stale bypass.
REQ-015 rdata SHALL hold its last value until the next read.

Reset
REQ-016 rst low SHALL immediately force: state IDLE, priority to a, clr_idx 0, all bank entries 0, rdata 0, rvalid 0, rsel 0, gnt_a/gnt_b 0, busy 0.
REQ-017 Reset mid-SERVE or mid-CLR SHALL abort with no gnt. The requester SHALL re-request after rst rises.

Configuration
REQ-018 SHALL have macro DFF_ARB_LOCK_EN.
- Defined: adds inputs lock_a and lock_b (1 bit each). If the winner's lock is high at its gnt and its req is still high in the next IDLE, the same requester wins again, overriding round-robin. Lock chains are unbounded.
- Undefined: lock ports are absent and round-robin always rotates.

Structure
REQ-019 Shared package dff_arb_pkg SHALL hold the opcode constants (OP_RD, OP_WR, OP_CLR, OP_CLRALL), the FSM state encoding and the DEPTH=4 constant.
REQ-020 The bank SHALL be a sub-module dff_bank_regs: async active-low clear, falling-edge write enable, entry addr, per-entry clear, combinational read port. It is instantiated once.

Verification
REQ-021 Bench SHALL cover these scenarios (WIDTH=8):
- Reset then a: write addr1=8'hA5. Then a: read addr1 -> gnt_a 2 cycles after req; rdata=8'hA5, rvalid=1, rsel=0 the cycle after the read's gnt.
- a and b request simultaneously from reset -> a granted first, b next (2 cycles later); repeated simultaneous requests alternate a,b,a,b.
- Fill entries 0..3 with 11,22,33,44, then b: clear-all -> busy 4 cycles in CLR, gnt_b on 4th; all reads return 0.
- b: write addr2=8'h3C, rst pulsed low during SERVE -> no gnt_b, bank all 0, read addr2 returns 0.
- a: clear entry addr0 after writing 8'hFF -> read returns 0, other entries unchanged.
- DFF_ARB_LOCK_EN: lock_a=1 with a and b both requesting -> a wins 3 consecutive grants; lock_a=0 -> b granted next.
